// File: rtl/rr_scheduler.sv
// Round-robin task scheduler with a fixed time quantum.
// Holds up to SLOTS tasks as {remaining time, id}. Each cycle one valid task is
// granted the shared execution slot and its remaining time drops by one.
//
// state  | meaning
// S_INIT | idle after reset; slots empty, arrivals ignored, waiting for st
// S_EXEC | scheduling: accepts arrivals, runs one task per cycle

module rr_scheduler #(
   parameter int SLOTS   = 5,
   parameter int QUANTUM = 2,
   parameter int ID_W    = 16,
   parameter int BURST_W = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      st,
   input  logic                      inputtask,
   input  logic [BURST_W+ID_W-1:0]   task_in,
   output logic                      empty,
   output logic                      full,
   output logic                      done,
   output logic [ID_W-1:0]           task_out
);

   localparam int CUR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int QW    = $clog2(QUANTUM + 1);

   typedef enum logic {S_INIT, S_EXEC} state_t;

   state_t               state;
   logic [BURST_W-1:0]   rem [SLOTS];
   logic [ID_W-1:0]      id  [SLOTS];
   logic [CUR_W-1:0]     cur;
   logic [QW-1:0]        qcnt;

   logic [SLOTS-1:0]     valid;
   logic                 any_valid;
   logic                 has_free;
   logic [CUR_W-1:0]     free_idx;
   logic                 cont;
   logic [CUR_W-1:0]     sel;
   logic                 found;
   logic                 running;

   wire [BURST_W-1:0]    in_burst = task_in[BURST_W+ID_W-1:ID_W];
   wire [ID_W-1:0]       in_id    = task_in[ID_W-1:0];

   // Slot occupancy and the lowest-index free slot (pre-edge view).
   always_comb begin
      valid    = '0;
      has_free = 1'b0;
      free_idx = '0;
      for (int i = 0; i < SLOTS; i++) begin
         valid[i] = (rem[i] != '0);
      end
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            has_free = 1'b1;
            free_idx = CUR_W'(i);
         end
      end
      any_valid = |valid;
      empty     = ~any_valid;
      full      = &valid;
   end

   // Pick the running task: keep cur while its quantum lasts, else scan circularly
   // starting after cur so that cur itself is considered last.
   always_comb begin
      int j;
      cont  = valid[cur] && (qcnt < QW'(QUANTUM));
      sel   = cur;
      found = cont;
      for (int k = 1; k <= SLOTS; k++) begin
         j = int'(cur) + k;
         if (j >= SLOTS) j = j - SLOTS;
         if (!found && valid[j]) begin
            found = 1'b1;
            sel   = CUR_W'(j);
         end
      end
      running  = (state == S_EXEC) && any_valid;
      task_out = running ? id[sel] : '1;
      done     = running && (rem[sel] == BURST_W'(1));
   end

   // FSM, slot storage, round-robin pointer and quantum counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_INIT;
         cur   <= '0;
         qcnt  <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            rem[i] <= '0;
            id[i]  <= '0;
         end
      end else begin
         case (state)
            S_INIT: begin
               if (st) state <= S_EXEC;
            end
            S_EXEC: begin
               if (any_valid) begin
                  rem[sel] <= rem[sel] - BURST_W'(1);
                  cur      <= sel;
                  qcnt     <= cont ? qcnt + QW'(1) : QW'(1);
               end else begin
                  qcnt <= '0;
               end
               // free_idx is never sel: sel is valid pre-edge, free_idx is not
               if (inputtask && has_free && (in_burst != '0)) begin
                  rem[free_idx] <= in_burst;
                  id[free_idx]  <= in_id;
               end
            end
            default: state <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_scheduler.sv
// Directed bench for rr_scheduler (SLOTS=5, QUANTUM=2).
// Inputs change 1 time unit after each rising edge; outputs are checked in that
// same settled window.

module tb_rr_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        st;
   logic        inputtask;
   logic [19:0] task_in;
   logic        empty;
   logic        full;
   logic        done;
   logic [15:0] task_out;

   int n_chk = 0;
   int n_err = 0;

   rr_scheduler #(.SLOTS(5), .QUANTUM(2), .ID_W(16), .BURST_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .st        (st),
      .inputtask (inputtask),
      .task_in   (task_in),
      .empty     (empty),
      .full      (full),
      .done      (done),
      .task_out  (task_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset_start();
      rst = 1'b1; st = 1'b0; inputtask = 1'b0; task_in = '0;
      cycle();
      rst = 1'b0; st = 1'b1;
      cycle();
      st = 1'b0;
   endtask

   logic [15:0] exp_t1 [6] = '{16'h00A1, 16'h00A1, 16'h00B2, 16'h00B2, 16'h00A1, 16'hFFFF};
   logic        exp_d1 [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   initial begin
      rst = 1'b1; st = 1'b0; inputtask = 1'b0; task_in = '0;
      cycle();
      rst = 1'b0;
      chk("rst_task_out", 32'(task_out), 32'hFFFF);
      chk("rst_empty",    32'(empty),    32'd1);
      chk("rst_full",     32'(full),     32'd0);
      chk("rst_done",     32'(done),     32'd0);

      // Test 1: A={3,A1}, B={2,B2} on consecutive cycles
      do_reset_start();
      for (int k = 0; k < 6; k++) begin
         inputtask = (k < 2);
         task_in   = (k == 0) ? {4'd3, 16'h00A1} : {4'd2, 16'h00B2};
         cycle();
         chk($sformatf("t1_out%0d", k),  32'(task_out), 32'(exp_t1[k]));
         chk($sformatf("t1_done%0d", k), 32'(done),     32'(exp_d1[k]));
      end
      inputtask = 1'b0;
      chk("t1_empty_after", 32'(empty), 32'd1);

      // Test 2: lone task runs 5 cycles without gap through quantum wrap
      do_reset_start();
      inputtask = 1'b1; task_in = {4'd5, 16'h0010};
      cycle();
      inputtask = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("t2_out%0d", k),  32'(task_out), 32'h0010);
         chk($sformatf("t2_done%0d", k), 32'(done),     32'(k == 4));
         cycle();
      end
      chk("t2_idle", 32'(task_out), 32'hFFFF);

      // Test 3: five tasks of burst 4, sixth dropped while full
      do_reset_start();
      for (int k = 0; k < 20; k++) begin
         inputtask = (k < 6);
         task_in   = (k < 5) ? {4'd4, 16'h0300 + 16'(k)} : {4'd4, 16'h0666};
         if (k == 5) chk("t3_full", 32'(full), 32'd1);
         cycle();
         chk($sformatf("t3_out%0d", k), 32'(task_out), 32'h0300 + 32'((k / 2) % 5));
         chk($sformatf("t3_done%0d", k), 32'(done), 32'((k >= 10) && (k % 2 == 1)));
      end
      inputtask = 1'b0;
      cycle();
      chk("t3_idle",  32'(task_out), 32'hFFFF);
      chk("t3_empty", 32'(empty),    32'd1);

      // Test 4: arrivals in S_INIT, including on the st edge, are ignored
      rst = 1'b1; st = 1'b0; inputtask = 1'b0;
      cycle();
      rst = 1'b0; inputtask = 1'b1; task_in = {4'd3, 16'h0044};
      cycle();
      chk("t4_init_empty", 32'(empty),    32'd1);
      chk("t4_init_out",   32'(task_out), 32'hFFFF);
      st = 1'b1;
      cycle();
      st = 1'b0; inputtask = 1'b0;
      chk("t4_st_empty", 32'(empty),    32'd1);
      cycle();
      chk("t4_exec_out", 32'(task_out), 32'hFFFF);

      // Test 5: rst mid-run (with st, rst wins); S_INIT holds despite arrivals
      do_reset_start();
      for (int k = 0; k < 3; k++) begin
         inputtask = 1'b1; task_in = {4'd4, 16'h0500 + 16'(k)};
         cycle();
      end
      inputtask = 1'b0;
      chk("t5_running", 32'(task_out), 32'h0501);
      rst = 1'b1; st = 1'b1; inputtask = 1'b1; task_in = {4'd2, 16'h0555};
      cycle();
      rst = 1'b0; st = 1'b0;
      chk("t5_rst_out",   32'(task_out), 32'hFFFF);
      chk("t5_rst_empty", 32'(empty),    32'd1);
      cycle();
      cycle();
      chk("t5_hold_empty", 32'(empty),    32'd1);
      chk("t5_hold_out",   32'(task_out), 32'hFFFF);
      inputtask = 1'b0;

      // Test 6: burst 0 is not stored; slot 0 remains usable
      do_reset_start();
      inputtask = 1'b1; task_in = {4'd0, 16'h1234};
      cycle();
      chk("t6_empty", 32'(empty),    32'd1);
      chk("t6_out",   32'(task_out), 32'hFFFF);
      task_in = {4'd1, 16'h00C6};
      cycle();
      inputtask = 1'b0;
      chk("t6_next_out",  32'(task_out), 32'h00C6);
      chk("t6_next_done", 32'(done),     32'd1);
      cycle();
      chk("t6_final_empty", 32'(empty), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
